// File: rtl/timer.sv
// 8-bit programmable up/down timer behind a zero-wait-state APB slave port.
// Define TIMER_IRQ_EN to add the TIER register at 0x03 and the tmr_irq output.
module timer (
  input  logic       pclk,
  input  logic       preset,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic       tmr_ovf,
  output logic       tmr_udf
`ifdef TIMER_IRQ_EN
  ,
  output logic       tmr_irq
`endif
);

  localparam logic [7:0] ADDR_TDR = 8'h00;
  localparam logic [7:0] ADDR_TCR = 8'h01;
  localparam logic [7:0] ADDR_TSR = 8'h02;
  localparam logic [7:0] TCR_MASK = 8'hB3;
`ifdef TIMER_IRQ_EN
  localparam logic [7:0] ADDR_TIER = 8'h03;
`endif

  logic [7:0] tdr_q, tdr_d;
  logic [7:0] tcr_q, tcr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] presc_q, presc_d;
  logic       ovf_q, ovf_d;
  logic       udf_q, udf_d;
`ifdef TIMER_IRQ_EN
  logic [1:0] tier_q, tier_d;
`endif

  logic       access, wr_en, rd_en;
  logic       sel_tdr, sel_tcr, sel_tsr, mapped;
  logic       tcr_load, tcr_down, tcr_en;
  logic [1:0] tcr_cks;
  logic [3:0] tick_mask;
  logic       tick;
  logic       ovf_set, udf_set;
  logic [7:0] rd_data;

  assign access   = psel & penable;
  assign wr_en    = access & pwrite;
  assign rd_en    = access & ~pwrite;
  assign tcr_load = tcr_q[7];
  assign tcr_down = tcr_q[5];
  assign tcr_en   = tcr_q[4];
  assign tcr_cks  = tcr_q[1:0];

  always_comb begin
    sel_tdr = (paddr == ADDR_TDR);
    sel_tcr = (paddr == ADDR_TCR);
    sel_tsr = (paddr == ADDR_TSR);
    mapped  = sel_tdr | sel_tcr | sel_tsr;
`ifdef TIMER_IRQ_EN
    mapped  = mapped | (paddr == ADDR_TIER);
`endif
  end

  // A tick fires when the low cks+1 prescaler bits are all ones, i.e. every 2^(cks+1) cycles.
  always_comb begin
    case (tcr_cks)
      2'd0:    tick_mask = 4'b0001;
      2'd1:    tick_mask = 4'b0011;
      2'd2:    tick_mask = 4'b0111;
      default: tick_mask = 4'b1111;
    endcase
    tick    = ((presc_q & tick_mask) == tick_mask);
    presc_d = presc_q + 4'd1;
  end

  // Load overrides counting and never raises a flag.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (tcr_load) begin
      cnt_d = tdr_q;
    end else if (tcr_en && tick) begin
      if (tcr_down) begin
        cnt_d   = cnt_q - 8'd1;
        udf_set = (cnt_q == 8'h00);
      end else begin
        cnt_d   = cnt_q + 8'd1;
        ovf_set = (cnt_q == 8'hFF);
      end
    end
  end

  always_comb begin
    tdr_d = tdr_q;
    tcr_d = tcr_q;
    if (wr_en && sel_tdr) tdr_d = pwdata;
    if (wr_en && sel_tcr) tcr_d = pwdata & TCR_MASK;
    ovf_d = ovf_set | (ovf_q & ~(wr_en & sel_tsr & pwdata[0]));
    udf_d = udf_set | (udf_q & ~(wr_en & sel_tsr & pwdata[1]));
`ifdef TIMER_IRQ_EN
    tier_d = tier_q;
    if (wr_en && (paddr == ADDR_TIER)) tier_d = pwdata[1:0];
`endif
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tdr_q   <= 8'h00;
      tcr_q   <= 8'h00;
      cnt_q   <= 8'h00;
      presc_q <= 4'h0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      tdr_q   <= tdr_d;
      tcr_q   <= tcr_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

`ifdef TIMER_IRQ_EN
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) tier_q <= 2'b00;
    else        tier_q <= tier_d;
  end

  assign tmr_irq = (ovf_q & tier_q[0]) | (udf_q & tier_q[1]);
`endif

  // Bus outputs are forced idle while reset is held, even mid-transfer.
  always_comb begin
    rd_data = 8'h00;
    if (sel_tdr)      rd_data = tdr_q;
    else if (sel_tcr) rd_data = tcr_q;
    else if (sel_tsr) rd_data = {6'b0, udf_q, ovf_q};
`ifdef TIMER_IRQ_EN
    else if (paddr == ADDR_TIER) rd_data = {6'b0, tier_q};
`endif
    prdata  = (rd_en && !preset) ? rd_data : 8'h00;
    pready  = access & ~preset;
    pslverr = access & ~preset & ~mapped;
  end

  assign tmr_ovf = ovf_q;
  assign tmr_udf = udf_q;

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: directed APB scenarios plus random traffic
// checked against a cycle-level arithmetic model of the register file and counter.
module tb_timer;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] paddr = 8'h00;
  logic [7:0] pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic       tmr_ovf;
  logic       tmr_udf;
`ifdef TIMER_IRQ_EN
  logic       tmr_irq;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  int m_tdr = 0;
  int m_tcr = 0;
  int m_tsr = 0;
  int m_tier = 0;
  int m_cnt = 0;
  int m_presc = 0;

  timer dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .tmr_ovf (tmr_ovf),
    .tmr_udf (tmr_udf)
`ifdef TIMER_IRQ_EN
    ,
    .tmr_irq (tmr_irq)
`endif
  );

  always #5 pclk = ~pclk;

  // Reference model: counts elapsed cycles and applies the register rules with plain arithmetic.
  always @(posedge pclk or posedge preset) begin
    int  div;
    bit  tick;
    bit  ovf_set;
    bit  udf_set;
    bit  wr;
    int  a;
    int  d;
    if (preset) begin
      m_tdr = 0; m_tcr = 0; m_tsr = 0; m_tier = 0; m_cnt = 0; m_presc = 0;
    end else begin
      div     = 2 << (m_tcr % 4);
      tick    = ((m_presc % div) == div - 1);
      ovf_set = 1'b0;
      udf_set = 1'b0;
      if ((m_tcr & 'h80) != 0) begin
        m_cnt = m_tdr;
      end else if (((m_tcr & 'h10) != 0) && tick) begin
        if ((m_tcr & 'h20) != 0) begin
          udf_set = (m_cnt == 0);
          m_cnt   = (m_cnt + 255) % 256;
        end else begin
          ovf_set = (m_cnt == 255);
          m_cnt   = (m_cnt + 1) % 256;
        end
      end
      wr = psel && penable && pwrite;
      a  = int'(paddr);
      d  = int'(pwdata);
      if (wr && a == 2) m_tsr = m_tsr & ~d & 3;
      if (ovf_set) m_tsr = m_tsr | 1;
      if (udf_set) m_tsr = m_tsr | 2;
      if (wr && a == 0) m_tdr = d;
      if (wr && a == 1) m_tcr = d & 'hB3;
`ifdef TIMER_IRQ_EN
      if (wr && a == 3) m_tier = d & 3;
`endif
      m_presc = (m_presc + 1) % 16;
    end
  end

  function automatic bit model_mapped(input int a);
`ifdef TIMER_IRQ_EN
    return (a <= 3);
`else
    return (a <= 2);
`endif
  endfunction

  function automatic int model_read(input int a);
    case (a)
      0: return m_tdr;
      1: return m_tcr;
      2: return m_tsr;
`ifdef TIMER_IRQ_EN
      3: return m_tier;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, "_ovf"}, 32'(tmr_ovf), 32'(m_tsr & 1));
    checkOutput({tag, "_udf"}, 32'(tmr_udf), 32'((m_tsr >> 1) & 1));
`ifdef TIMER_IRQ_EN
    checkOutput({tag, "_irq"}, 32'(tmr_irq), 32'((m_tsr & m_tier) != 0));
`endif
  endtask

  task automatic applyStimulus(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                               output logic [7:0] rdata, output logic err);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    #1;
    checkOutput("setup_pready", 32'(pready), 32'd0);
    @(negedge pclk);
    penable = 1'b1;
    #1;
    checkOutput("pready", 32'(pready), 32'd1);
    checkOutput("pslverr", 32'(pslverr), 32'(!model_mapped(int'(addr))));
    if (!wr) checkOutput("prdata", 32'(prdata), 32'(model_read(int'(addr))));
    else     checkOutput("prdata_wr", 32'(prdata), 32'd0);
    rdata = prdata;
    err   = pslverr;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #1;
    checkOutput("idle_prdata", 32'(prdata), 32'd0);
    checkFlags("post");
  endtask

  task automatic do_reset();
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic       err;
    int         a;
    logic [7:0] d;

    $display("[TB] start");
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    #1;
    checkOutput("rst_pready", 32'(pready), 32'd0);
    checkFlags("rst");

    // Reset values of the mapped registers
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'(i), 8'h00, rd, err);
      checkOutput("rst_reg", 32'(rd), 32'd0);
      checkOutput("rst_reg_err", 32'(err), 32'd0);
    end

    // Plain register access and reserved TCR bits
    applyStimulus(1'b1, 8'h00, 8'hA5, rd, err);
    applyStimulus(1'b0, 8'h00, 8'h00, rd, err);
    checkOutput("tdr_rw", 32'(rd), 32'hA5);
    applyStimulus(1'b1, 8'h01, 8'hFF, rd, err);
    applyStimulus(1'b0, 8'h01, 8'h00, rd, err);
    checkOutput("tcr_rw", 32'(rd), 32'hB3);

    // Unmapped addresses have no side effects
    do_reset();
    for (int ad = 8'hFE; ad >= 8'hCD; ad--) begin
      applyStimulus(1'b1, 8'(ad), 8'($urandom_range(0, 255)), rd, err);
      checkOutput("unmapped_err", 32'(err), 32'd1);
      applyStimulus(1'b0, 8'h00, 8'h00, rd, err);
      checkOutput("unmapped_tdr", 32'(rd), 32'd0);
    end

    // Overflow scenario, up count at /2
`ifdef TIMER_IRQ_EN
    applyStimulus(1'b1, 8'h03, 8'h01, rd, err);
    applyStimulus(1'b0, 8'h03, 8'h00, rd, err);
    checkOutput("tier_rw", 32'(rd), 32'h01);
`endif
    applyStimulus(1'b1, 8'h00, 8'hFE, rd, err);
    applyStimulus(1'b1, 8'h01, 8'h80, rd, err);
    applyStimulus(1'b1, 8'h01, 8'h10, rd, err);
    repeat (4) @(posedge pclk);
    @(negedge pclk);
    #1;
    checkOutput("ovf_set", 32'(tmr_ovf), 32'd1);
    checkFlags("ovf");
`ifdef TIMER_IRQ_EN
    checkOutput("irq_set", 32'(tmr_irq), 32'd1);
`endif
    applyStimulus(1'b0, 8'h02, 8'h00, rd, err);
    checkOutput("tsr_ovf", 32'(rd), 32'h01);
    applyStimulus(1'b1, 8'h02, 8'h01, rd, err);
`ifdef TIMER_IRQ_EN
    checkOutput("irq_clr", 32'(tmr_irq), 32'd0);
`endif
    applyStimulus(1'b0, 8'h02, 8'h00, rd, err);
    checkOutput("tsr_clr", 32'(rd), 32'h00);

    // Underflow scenario, down count at /16
    applyStimulus(1'b1, 8'h01, 8'h00, rd, err);
    applyStimulus(1'b1, 8'h00, 8'h01, rd, err);
    applyStimulus(1'b1, 8'h01, 8'h80, rd, err);
    applyStimulus(1'b1, 8'h01, 8'h33, rd, err);
    repeat (32) @(posedge pclk);
    @(negedge pclk);
    #1;
    checkOutput("udf_set", 32'(tmr_udf), 32'd1);
    checkFlags("udf");
    applyStimulus(1'b1, 8'h02, 8'h01, rd, err);
    applyStimulus(1'b0, 8'h02, 8'h00, rd, err);
    checkOutput("tsr_udf_kept", 32'(rd), 32'h02);

    // Reset in the middle of an access phase
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h02;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    preset = 1'b1;
    #1;
    checkOutput("midrst_pready", 32'(pready), 32'd0);
    checkOutput("midrst_prdata", 32'(prdata), 32'd0);
    checkOutput("midrst_pslverr", 32'(pslverr), 32'd0);
    checkOutput("midrst_udf", 32'(tmr_udf), 32'd0);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    preset = 1'b0;

    // Random traffic biased toward wrap-prone load values
    for (int it = 0; it < 150; it++) begin
      a = $urandom_range(0, 5);
      if (a > 3) a = $urandom_range(4, 255);
      d = 8'($urandom_range(0, 255));
      if (a == 0 && $urandom_range(0, 1) == 1) d = 8'($urandom_range(0, 1) ? $urandom_range(250, 255) : $urandom_range(0, 5));
      applyStimulus($urandom_range(0, 9) < 5, 8'(a), d, rd, err);
      repeat ($urandom_range(0, 3)) @(negedge pclk);
      #1;
      checkFlags("rand_idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
